intc_entry_seq: RTL

// Interrupt-entry sequencer between the INTC and the CPU core. Accepts the INTC's pending request at an

---
 rtl/intc_entry_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/intc_entry_seq.sv
// intc_entry_seq: interrupt-entry sequencer sitting between the INTC and the CPU core.
// It takes a pending request at an instruction boundary and runs the vector handshake.
// It then pushes SR and PC, fetches the handler address, and hands NEW_PC/NEW_SP/NEW_SR_I
// back to the core. The core is held stalled while the entry runs.
// Optional feature: define INT_ENTRY_ADDR_ERR_EN to reject entries whose SP or VBR is not
// word aligned. A rejected entry pulses ADDR_ERR instead of running.
module intc_entry_seq #(
    parameter logic [7:0] VEC_NMI  = 8'd11,
    parameter int         STK_STEP = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    output logic        INT_ACK,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    input  logic        INST_BND,
    input  logic [3:0]  SR_I,
    input  logic [31:0] SR_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] SP_IN,
    input  logic [31:0] VBR,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_DO,
    input  logic [31:0] MEM_DI,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_WAIT,
    output logic        CORE_STALL,
    output logic        ENTRY_DONE,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_SP,
    output logic [3:0]  NEW_SR_I,
    output logic        ADDR_ERR
);

    localparam logic [31:0] STEP1 = 32'(STK_STEP);
    localparam logic [31:0] STEP2 = 32'(2 * STK_STEP);

    typedef enum logic [2:0] {
        IDLE, VREQ, VWAIT, PUSH_SR, PUSH_PC, RD_VEC, DONE
    } state_t;

    state_t      state;
    logic [3:0]  lvl_q;
    logic [31:0] sr_q, pc_q, sp_q, vbr_q;
    logic [7:0]  vec_q;
    logic        accept;
    logic        reject;

    // NMI vector bypasses the level mask
    assign accept = INT_REQ & INST_BND & ((INT_LVL > SR_I) | (INT_VEC == VEC_NMI));

`ifdef INT_ENTRY_ADDR_ERR_EN
    logic addr_err_q;
    assign reject   = (SP_IN[1:0] != 2'b00) | (VBR[1:0] != 2'b00);
    assign ADDR_ERR = addr_err_q;
`else
    assign reject   = 1'b0;
    assign ADDR_ERR = 1'b0;
`endif

    // Entry FSM; all outputs registered. Reset wins over CE_R so a mid-entry reset
    // drops the bus and vector requests immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            lvl_q      <= '0;
            sr_q       <= '0;
            pc_q       <= '0;
            sp_q       <= '0;
            vbr_q      <= '0;
            vec_q      <= '0;
            INT_ACK    <= 1'b0;
            VECT_REQ   <= 1'b0;
            MEM_A      <= '0;
            MEM_DO     <= '0;
            MEM_WE     <= 1'b0;
            MEM_REQ    <= 1'b0;
            CORE_STALL <= 1'b0;
            ENTRY_DONE <= 1'b0;
            NEW_PC     <= '0;
            NEW_SP     <= '0;
            NEW_SR_I   <= '0;
`ifdef INT_ENTRY_ADDR_ERR_EN
            addr_err_q <= 1'b0;
`endif
        end else if (CE_R) begin
            INT_ACK    <= 1'b0;
            ENTRY_DONE <= 1'b0;
`ifdef INT_ENTRY_ADDR_ERR_EN
            addr_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    CORE_STALL <= 1'b0;
                    if (accept && reject) begin
                        // misaligned stack/table: one-cycle stall, no handshake, no bus
                        CORE_STALL <= 1'b1;
`ifdef INT_ENTRY_ADDR_ERR_EN
                        addr_err_q <= 1'b1;
`endif
                    end else if (accept) begin
                        lvl_q      <= INT_LVL;
                        sr_q       <= SR_IN;
                        pc_q       <= PC_IN;
                        sp_q       <= SP_IN;
                        vbr_q      <= VBR;
                        CORE_STALL <= 1'b1;
                        VECT_REQ   <= 1'b1;
                        state      <= VREQ;
                    end
                end
                VREQ: begin
                    VECT_REQ <= 1'b0;
                    state    <= VWAIT;
                end
                VWAIT: begin
                    if (!VECT_WAIT) begin
                        vec_q   <= INT_VEC;
                        INT_ACK <= 1'b1;
                        MEM_REQ <= 1'b1;
                        MEM_WE  <= 1'b1;
                        MEM_A   <= sp_q - STEP1;
                        MEM_DO  <= sr_q;
                        state   <= PUSH_SR;
                    end
                end
                PUSH_SR: begin
                    if (!MEM_WAIT) begin
                        MEM_A  <= sp_q - STEP2;
                        MEM_DO <= pc_q;
                        state  <= PUSH_PC;
                    end
                end
                PUSH_PC: begin
                    if (!MEM_WAIT) begin
                        MEM_WE <= 1'b0;
                        MEM_DO <= '0;
                        MEM_A  <= vbr_q + {22'b0, vec_q, 2'b00};
                        state  <= RD_VEC;
                    end
                end
                RD_VEC: begin
                    if (!MEM_WAIT) begin
                        MEM_REQ    <= 1'b0;
                        MEM_A      <= '0;
                        NEW_PC     <= MEM_DI;
                        NEW_SP     <= sp_q - STEP2;
                        NEW_SR_I   <= lvl_q;
                        ENTRY_DONE <= 1'b1;
                        CORE_STALL <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
